// File: rtl/id_regfile_sb_if.sv
// ID-stage register file bus: read ports, writeback port, issue port.
// The master side is decode/WB, the slave side is the register file.
interface id_regfile_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int NUM_RD = 2
);
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     wb_en;
   logic [ADDR_W-1:0]        wb_dest;
   logic [DATA_W-1:0]        wb_value;
   logic                     iss_en;
   logic [ADDR_W-1:0]        iss_dest;
   logic                     iss_ok;

   modport master (
      output rd_addr, wb_en, wb_dest, wb_value, iss_en, iss_dest,
      input  rd_data, rd_busy, iss_ok
   );

   modport slave (
      input  rd_addr, wb_en, wb_dest, wb_value, iss_en, iss_dest,
      output rd_data, rd_busy, iss_ok
   );
endinterface

// File: rtl/id_regfile_sb.sv
// ID-stage register file with a per-register pending-write scoreboard.
// Reads are combinational; writes land on posedge. Each register carries a
// saturating count of issued-but-not-written-back instructions targeting it,
// used by decode to flag RAW hazards (rd_busy) and to stall issue (iss_ok).
// Optional feature macro: WRITE_BYPASS_EN forwards a same-cycle writeback to
// the read ports and clears busy when that writeback resolves the last pending
// write. The interface parameters must match DATA_W/ADDR_W/NUM_RD here.
module id_regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 15,
   parameter int ADDR_W   = 4,
   parameter int NUM_RD   = 2,
   parameter int PEND_W   = 2
) (
   input logic            clk,
   input logic            rst,
   id_regfile_sb_if.slave bus
);

   localparam logic [PEND_W-1:0] CNT_MAX = '1;

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [PEND_W-1:0]   cnt  [NUM_REGS];
   logic [NUM_REGS-1:0] wr_vec;
   logic [NUM_REGS-1:0] inc_vec;
   logic [NUM_REGS-1:0] dec_vec;
   logic                iss_hit_max;

   function automatic logic is_mapped(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < (ADDR_W+1)'(NUM_REGS);
   endfunction

   // Read ports: unmapped addresses match no register and read as zero, not busy.
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] val;
      logic [PEND_W-1:0] pend;

      assign addr = bus.rd_addr[k*ADDR_W +: ADDR_W];

      // Select the stored value and pending count for this port's address.
      always_comb begin
         val  = '0;
         pend = '0;
         for (int r = 0; r < NUM_REGS; r++) begin
            if (addr == ADDR_W'(r)) begin
               val  = regs[r];
               pend = cnt[r];
            end
         end
      end

`ifdef WRITE_BYPASS_EN
      logic byp;
      assign byp = bus.wb_en && (bus.wb_dest == addr) && is_mapped(addr);
      assign bus.rd_data[k*DATA_W +: DATA_W] = byp ? bus.wb_value : val;
      // The final outstanding write is satisfied by the forwarded value.
      assign bus.rd_busy[k] = (pend != '0) && !(byp && (pend == PEND_W'(1)));
`else
      assign bus.rd_data[k*DATA_W +: DATA_W] = val;
      assign bus.rd_busy[k] = (pend != '0);
`endif
   end

   // Issue is refused only when a mapped destination's counter is saturated.
   always_comb begin
      iss_hit_max = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if ((bus.iss_dest == ADDR_W'(r)) && (cnt[r] == CNT_MAX)) iss_hit_max = 1'b1;
      end
   end

   assign bus.iss_ok = ~iss_hit_max;

   // Per-register write strobe and scoreboard increment/decrement requests.
   always_comb begin
      wr_vec  = '0;
      inc_vec = '0;
      dec_vec = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         wr_vec[r]  = bus.wb_en && (bus.wb_dest == ADDR_W'(r));
         inc_vec[r] = bus.iss_en && bus.iss_ok && (bus.iss_dest == ADDR_W'(r));
         dec_vec[r] = wr_vec[r] && (cnt[r] != '0);
      end
   end

   // Register array and pending counters; reset drops all in-flight counts.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs[r] <= DATA_W'(r);
            cnt[r]  <= '0;
         end
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (wr_vec[r]) regs[r] <= bus.wb_value;
            if (inc_vec[r] && !dec_vec[r])      cnt[r] <= cnt[r] + PEND_W'(1);
            else if (dec_vec[r] && !inc_vec[r]) cnt[r] <= cnt[r] - PEND_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_id_regfile_sb.sv
// Bench for id_regfile_sb: a reference model computes expected read data,
// busy flags and iss_ok when inputs are driven; the expectation is queued and
// compared against the DUT on the following falling edge. Directed checks
// cover the documented scenarios; a random sweep follows.
module tb_id_regfile_sb;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 4;
   localparam int NUM_RD = 2;

   logic clk;
   logic rst;

   id_regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

   id_regfile_sb #(
      .DATA_W(DATA_W), .NUM_REGS(15), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .PEND_W(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      logic [63:0] data;
      logic [1:0]  busy;
      logic        ok;
   } exp_t;

   exp_t sb_q[$];

   logic [31:0] m_reg [16];
   logic [1:0]  m_cnt [16];

   function automatic logic mapped(input logic [3:0] a);
      return a < 4'd15;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_reg[i] = (i < 15) ? 32'(i) : 32'd0;
         m_cnt[i] = 2'd0;
      end
   endtask

   function automatic logic model_ok(input logic [3:0] id);
      return !(mapped(id) && m_cnt[id] == 2'd3);
   endfunction

   task automatic drive(input logic [3:0] a0, input logic [3:0] a1,
                        input logic we, input logic [3:0] wd, input logic [31:0] wv,
                        input logic ie, input logic [3:0] id);
      exp_t e;
      logic [3:0]  a;
      logic [31:0] d;
      logic [1:0]  c;
      bus.rd_addr  = {a1, a0};
      bus.wb_en    = we;
      bus.wb_dest  = wd;
      bus.wb_value = wv;
      bus.iss_en   = ie;
      bus.iss_dest = id;
      for (int p = 0; p < 2; p++) begin
         a = (p == 0) ? a0 : a1;
         d = mapped(a) ? m_reg[a] : 32'd0;
         c = mapped(a) ? m_cnt[a] : 2'd0;
         e.busy[p] = (c != 2'd0);
`ifdef WRITE_BYPASS_EN
         if (we && wd == a && mapped(a)) begin
            d = wv;
            if (c == 2'd1) e.busy[p] = 1'b0;
         end
`endif
         e.data[p*32 +: 32] = d;
      end
      e.ok = model_ok(id);
      sb_q.push_back(e);
   endtask

   task automatic idle(input logic [3:0] a0, input logic [3:0] a1);
      drive(a0, a1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
   endtask

   task automatic tick();
      logic inc, dec, ok;
      logic [3:0] wd, id;
      @(posedge clk);
      wd  = bus.wb_dest;
      id  = bus.iss_dest;
      ok  = model_ok(id);
      inc = bus.iss_en && ok && mapped(id);
      dec = bus.wb_en && mapped(wd) && m_cnt[wd] != 2'd0;
      if (bus.wb_en && mapped(wd)) m_reg[wd] = bus.wb_value;
      if (!(inc && dec && id == wd)) begin
         if (inc) m_cnt[id] = m_cnt[id] + 2'd1;
         if (dec) m_cnt[wd] = m_cnt[wd] - 2'd1;
      end
      #1;
   endtask

   // Monitor: compare the queued expectation against the DUT mid-cycle.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         chk("rd_data", bus.rd_data, e.data);
         chk("rd_busy", 64'(bus.rd_busy), 64'(e.busy));
         chk("iss_ok", 64'(bus.iss_ok), 64'(e.ok));
      end
   end

   initial begin
      rst = 1'b0;
      bus.rd_addr  = {4'd7, 4'd3};
      bus.wb_en    = 1'b0;
      bus.wb_dest  = 4'd0;
      bus.wb_value = 32'd0;
      bus.iss_en   = 1'b0;
      bus.iss_dest = 4'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold_data", bus.rd_data, {32'd7, 32'd3});
      rst = 1'b1;

      // Reset state
      idle(4'd3, 4'd7);
      #1;
      chk("reset_data", bus.rd_data, {32'd7, 32'd3});
      chk("reset_busy", 64'(bus.rd_busy), 64'd0);
      chk("reset_iss_ok", 64'(bus.iss_ok), 64'd1);
      tick();

      // Issue then writeback on reg5
      drive(4'd5, 4'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd5);
      #1;
      chk("own_src_not_busy", 64'(bus.rd_busy[0]), 64'd0);
      tick();
      idle(4'd5, 4'd0);
      #1;
      chk("busy_after_issue", 64'(bus.rd_busy[0]), 64'd1);
      tick();
      idle(4'd5, 4'd0);
      tick();
      drive(4'd5, 4'd0, 1'b1, 4'd5, 32'hDEAD, 1'b0, 4'd0);
      #1;
`ifdef WRITE_BYPASS_EN
      chk("wb_cycle_busy", 64'(bus.rd_busy[0]), 64'd0);
      chk("wb_cycle_data", 64'(bus.rd_data[31:0]), 64'hDEAD);
`else
      chk("wb_cycle_busy", 64'(bus.rd_busy[0]), 64'd1);
      chk("wb_cycle_data", 64'(bus.rd_data[31:0]), 64'd5);
`endif
      tick();
      idle(4'd5, 4'd0);
      #1;
      chk("after_wb_busy", 64'(bus.rd_busy[0]), 64'd0);
      chk("after_wb_data", 64'(bus.rd_data[31:0]), 64'hDEAD);
      tick();

      // Saturation on reg2
      for (int i = 0; i < 3; i++) begin
         drive(4'd0, 4'd2, 1'b0, 4'd0, 32'd0, 1'b1, 4'd2);
         tick();
      end
      drive(4'd0, 4'd2, 1'b0, 4'd0, 32'd0, 1'b1, 4'd2);
      #1;
      chk("sat_iss_ok", 64'(bus.iss_ok), 64'd0);
      tick();
      drive(4'd0, 4'd2, 1'b1, 4'd2, 32'h22, 1'b0, 4'd2);
      #1;
      chk("sat_still_full", 64'(bus.iss_ok), 64'd0);
      tick();
      idle(4'd0, 4'd2);
      bus.iss_dest = 4'd2;
      #1;
      chk("sat_release_ok", 64'(bus.iss_ok), 64'd1);
      chk("sat_release_busy", 64'(bus.rd_busy[1]), 64'd1);
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(4'd0, 4'd2, 1'b1, 4'd2, 32'h22, 1'b0, 4'd0);
         tick();
      end
      idle(4'd0, 4'd2);
      #1;
      chk("sat_drained", 64'(bus.rd_busy[1]), 64'd0);
      tick();

      // Simultaneous issue and writeback on reg4
      drive(4'd4, 4'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd4);
      tick();
      drive(4'd4, 4'd0, 1'b1, 4'd4, 32'h44, 1'b1, 4'd4);
      tick();
      idle(4'd4, 4'd0);
      #1;
      chk("simul_busy", 64'(bus.rd_busy[0]), 64'd1);
      chk("simul_data", 64'(bus.rd_data[31:0]), 64'h44);
      tick();
      drive(4'd4, 4'd0, 1'b1, 4'd4, 32'h45, 1'b0, 4'd0);
      tick();

      // Unmapped and stray writebacks
      drive(4'd15, 4'd14, 1'b1, 4'd15, 32'hFFFF_FFFF, 1'b0, 4'd0);
      tick();
      idle(4'd15, 4'd14);
      #1;
      chk("unmapped_data", bus.rd_data, {32'd14, 32'd0});
      chk("unmapped_busy", 64'(bus.rd_busy), 64'd0);
      tick();
      drive(4'd0, 4'd0, 1'b1, 4'd6, 32'h66, 1'b0, 4'd0);
      tick();
      idle(4'd6, 4'd0);
      bus.iss_dest = 4'd6;
      #1;
      chk("stray_wb_data", 64'(bus.rd_data[31:0]), 64'h66);
      chk("stray_wb_busy", 64'(bus.rd_busy[0]), 64'd0);
      tick();

      // Mid-operation asynchronous reset
      drive(4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd1);
      tick();
      drive(4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd1);
      tick();
      bus.rd_addr = {4'd5, 4'd1};
      bus.iss_en  = 1'b0;
      #1;
      chk("pre_rst_busy", 64'(bus.rd_busy[0]), 64'd1);
      rst = 1'b0;
      #1;
      chk("async_rst_busy", 64'(bus.rd_busy), 64'd0);
      chk("async_rst_data", bus.rd_data, {32'd5, 32'd1});
      #1;
      rst = 1'b1;
      model_reset();
      idle(4'd1, 4'd5);
      tick();
      drive(4'd1, 4'd0, 1'b1, 4'd1, 32'h111, 1'b0, 4'd0);
      tick();
      idle(4'd1, 4'd0);
      #1;
      chk("post_rst_wb_data", 64'(bus.rd_data[31:0]), 64'h111);
      chk("post_rst_wb_busy", 64'(bus.rd_busy[0]), 64'd0);
      tick();

      // Random sweep
      for (int i = 0; i < 400; i++) begin
         drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), $urandom,
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
         tick();
      end

      @(negedge clk);
      #1;
      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
